// File: rtl/mary_modulator.sv
// rtl/mary_modulator.sv - M-ary PSK/ASK carrier modulator with input symbol FIFO
//
// Purpose:
//   Accepts BPS-bit symbols through a valid/ready handshake into a small FIFO
//   and emits one unsigned carrier period (SPS samples) per symbol on clk_fast.
//   PSK rotates the sine table by sym*SPS/M samples; ASK scales the sine by
//   (sym+1)/M. Symbol timing comes from an internal sample counter k, so
//   consecutive symbols are emitted back-to-back with no gap.
//
// Parameters:
//   WAV_W       output sample width (offset binary, midscale MID = 2^(WAV_W-1))
//   SPS         samples per symbol = one carrier period (power of two, 4..64)
//   BPS         bits per symbol, 1..3 (M = 2^BPS)
//   FIFO_DEPTH  input symbol FIFO depth (power of two, >= 2)
//
// Ports:
//   clk_fast    sample clock
//   rst         asynchronous active-low reset
//   mode        0 = PSK, 1 = ASK; latched at each symbol start
//   in_valid    symbol offered on sym_in
//   in_ready    FIFO not full
//   sym_in      symbol value
//   wav_out     carrier sample (registered)
//   out_valid   wav_out carries a symbol sample
//   sym_start   pulse on the cycle wav_out shows sample k=0
//   fifo_level  current FIFO occupancy
//
// Optional feature:
//   NOISE_EN    when defined, a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1,
//               seed 16'hACE1) adds saturating +/-2*n[3:0] noise to wav_out,
//               including the idle midscale level.

module mary_modulator #(
  parameter int WAV_W      = 8,
  parameter int SPS        = 16,
  parameter int BPS        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_fast,
  input  logic                        rst,
  input  logic                        mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BPS-1:0]              sym_in,
  output logic [WAV_W-1:0]            wav_out,
  output logic                        out_valid,
  output logic                        sym_start,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int KW  = $clog2(SPS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int MID = 1 << (WAV_W - 1);
  localparam int AMP = MID - 1;
  // Signed working width: holds S*(sym+1) plus the midscale offset.
  localparam int CW  = WAV_W + BPS + 2;

  // pi in Q30 fixed point, used by the elaboration-time sine generator.
  localparam longint PI_Q30 = 64'sd3373259426;

  // round(AMP * sin(2*pi*i/SPS)), evaluated with a Q30 Taylor series on the
  // first quadrant and folded by symmetry so the series always converges fast.
  function automatic int sine_val(input int i);
    int     j;
    int     r;
    bit     neg;
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint prod;
    j   = i % SPS;
    neg = 1'b0;
    if (j >= SPS / 2) begin
      j   = j - SPS / 2;
      neg = 1'b1;
    end
    if (j > SPS / 4) begin
      j = SPS / 2 - j;
    end
    x    = (longint'(j) * 64'sd2 * PI_Q30) / longint'(SPS);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n <= 6; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    prod = longint'(AMP) * acc + (64'sd1 <<< 29);
    r    = int'(prod >>> 30);
    return neg ? -r : r;
  endfunction

  logic signed [WAV_W-1:0] sine_tab [SPS];

  for (genvar g = 0; g < SPS; g++) begin : g_sine
    localparam int SV = sine_val(g);
    assign sine_tab[g] = SV[WAV_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Input symbol FIFO
  // ---------------------------------------------------------------------------
  logic [BPS-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  count;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

  assign full       = (count == LW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  // Readiness depends on fullness only; a same-cycle pop never frees a slot
  // for a push at full.
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign fifo_level = count;

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk_fast) begin
    if (push) begin
      fifo_mem[wr_ptr] <= sym_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Symbol sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [KW-1:0]  k;
  logic [BPS-1:0] sym_r;
  logic           mode_r;
  logic           last;

  assign last = (k == KW'(SPS - 1));

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = RUN;
      RUN:     if (last && empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A new symbol is taken either from idle or exactly at the last sample of
  // the current one, which keeps back-to-back symbols gapless.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !empty;
      RUN:     pop = last && !empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      k      <= '0;
      sym_r  <= '0;
      mode_r <= 1'b0;
    end else if (pop) begin
      k      <= '0;
      sym_r  <= fifo_mem[rd_ptr];
      mode_r <= mode;
    end else if (state == RUN) begin
      k      <= k + KW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Waveform generation
  // ---------------------------------------------------------------------------
  logic [KW+BPS-1:0]    psk_off;
  logic [KW-1:0]        psk_idx;
  logic [BPS:0]         ask_mul;
  logic signed [CW-1:0] psk_ext;
  logic signed [CW-1:0] s_ext;
  logic signed [CW-1:0] m_ext;
  logic signed [CW-1:0] ask_prod;
  logic signed [CW-1:0] ask_val;
  logic signed [CW-1:0] clean_s;
  logic [WAV_W-1:0]     clean_u;
  logic [WAV_W-1:0]     wav_nxt;

  // Phase offset sym*SPS/M, taken modulo SPS by keeping the low KW bits.
  assign psk_off = {sym_r, {KW{1'b0}}} >> BPS;
  assign psk_idx = k + psk_off[KW-1:0];
  assign psk_ext = {{(CW-WAV_W){sine_tab[psk_idx][WAV_W-1]}}, sine_tab[psk_idx]};

  assign ask_mul  = {1'b0, sym_r} + (BPS+1)'(1);
  assign s_ext    = {{(CW-WAV_W){sine_tab[k][WAV_W-1]}}, sine_tab[k]};
  assign m_ext    = {{(CW-BPS-1){1'b0}}, ask_mul};
  assign ask_prod = s_ext * m_ext;
  // Arithmetic shift floors negative products (e.g. -127 >>> 1 = -64).
  assign ask_val  = ask_prod >>> BPS;

  assign clean_s = CW'(MID) + (mode_r ? ask_val : psk_ext);
  assign clean_u = (state == RUN) ? clean_s[WAV_W-1:0] : WAV_W'(MID);

`ifdef NOISE_EN
  logic [15:0]      lfsr;
  logic             lfsr_fb;
  logic [WAV_W-1:0] noise_mag;
  logic [WAV_W:0]   noise_up;

  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end

  // lfsr[4] selects direction, lfsr[3:0] doubled is the magnitude; both
  // directions saturate at the code range limits.
  assign noise_mag = WAV_W'({lfsr[3:0], 1'b0});
  assign noise_up  = {1'b0, clean_u} + {1'b0, noise_mag};

  always_comb begin
    wav_nxt = noise_up[WAV_W-1:0];
    if (lfsr[4]) begin
      wav_nxt = (clean_u < noise_mag) ? '0 : (clean_u - noise_mag);
    end else if (noise_up[WAV_W]) begin
      wav_nxt = '1;
    end
  end
`else
  assign wav_nxt = clean_u;
`endif

  // Output register: everything shown on the outputs lags the sequencer by
  // one cycle, so sym_start lines up with the k=0 sample.
  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      wav_out   <= WAV_W'(MID);
      out_valid <= 1'b0;
      sym_start <= 1'b0;
    end else begin
      wav_out   <= wav_nxt;
      out_valid <= (state == RUN);
      sym_start <= (state == RUN) && (k == '0);
    end
  end

endmodule
